sc_lanescheduler: RTL and testbench

- Timing and sequencing controller for the obstacle-lane matrix (car/log lanes).
- Divides CLOCK_50 into game ticks. On each tick, sweeps all lanes in order. Issues a one-lane-at-a-time shift request with direction to the lane register bank. After each sweep, pulses a collision-check strobe so the game FSM samples its matrix comparator.
- Speed per lane depends on lane index and the current level. The game FSM can pause the block and restart it.

---
 rtl/sc_lanescheduler.sv | 218 +++++++++++++++++++++
 tb/tb_sc_lanescheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_lanescheduler.sv
// sc_lanescheduler -- tick and sweep sequencer for the obstacle-lane matrix.
//
// Divides the system clock into game ticks. On every tick it sweeps the lanes
// in index order. Each lane that is due to move this frame gets a single
// one-hot shift request, held until the lane bank acknowledges it. After the
// last lane a one-cycle collision-check strobe is issued. All outputs are
// registered, so an asynchronous reset forces them to idle immediately.
//
// Ports:
//   SC_LANESCHEDULER_CLOCK_50              in   system clock
//   SC_LANESCHEDULER_RESET_InLow           in   async reset, active low
//   SC_LANESCHEDULER_startGame_InLow       in   restart request (low = restart)
//   SC_LANESCHEDULER_pause_InLow           in   low freezes the tick prescaler
//   SC_LANESCHEDULER_level_InBUS           in   current level, 0 = slowest
//   SC_LANESCHEDULER_laneDir_InBUS         in   per-lane direction, 1 = right
//   SC_LANESCHEDULER_shiftAck_InLow        in   lane bank done with the shift
//   SC_LANESCHEDULER_shiftReq_OutLow       out  shift request, active low
//   SC_LANESCHEDULER_shiftLeft_OutBUS      out  one-hot lane to shift left
//   SC_LANESCHEDULER_shiftRight_OutBUS     out  one-hot lane to shift right
//   SC_LANESCHEDULER_checkCollision_OutLow out  one-cycle strobe after a sweep
//   SC_LANESCHEDULER_busy_OutLow           out  low while a sweep is running
module sc_lanescheduler #(
  parameter int NUM_LANES       = 8,
  parameter int PRESCALER_WIDTH = 22,
  parameter int BASE_PERIOD     = 2500000,
  parameter int LEVEL_WIDTH     = 2
) (
  input  logic                   SC_LANESCHEDULER_CLOCK_50,
  input  logic                   SC_LANESCHEDULER_RESET_InLow,
  input  logic                   SC_LANESCHEDULER_startGame_InLow,
  input  logic                   SC_LANESCHEDULER_pause_InLow,
  input  logic [LEVEL_WIDTH-1:0] SC_LANESCHEDULER_level_InBUS,
  input  logic [NUM_LANES-1:0]   SC_LANESCHEDULER_laneDir_InBUS,
  input  logic                   SC_LANESCHEDULER_shiftAck_InLow,
  output logic                   SC_LANESCHEDULER_shiftReq_OutLow,
  output logic [NUM_LANES-1:0]   SC_LANESCHEDULER_shiftLeft_OutBUS,
  output logic [NUM_LANES-1:0]   SC_LANESCHEDULER_shiftRight_OutBUS,
  output logic                   SC_LANESCHEDULER_checkCollision_OutLow,
  output logic                   SC_LANESCHEDULER_busy_OutLow
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [IDX_W-1:0]           LAST_IDX   = IDX_W'(NUM_LANES - 1);
  localparam logic [PRESCALER_WIDTH-1:0] TERM_COUNT = PRESCALER_WIDTH'(BASE_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_SCAN      = 3'd2,
    ST_REQ       = 3'd3,
    ST_COLLIDE   = 3'd4
  } state_t;

  // Lane moves when the low s bits of the frame are zero, where
  // s = (lane mod 4) - level saturated at 0. Higher levels shrink s, so
  // level 3 makes every lane move every frame.
  function automatic logic lane_eligible(input logic [IDX_W-1:0]       lane,
                                         input logic [LEVEL_WIDTH-1:0] lvl,
                                         input logic [2:0]             frm);
    logic [1:0] lane_mod;
    int         shift_v;
    logic [2:0] mask;
    lane_mod = 2'(lane);
    shift_v  = int'(lane_mod) - int'(lvl);
    if (shift_v < 32'sd0) begin
      shift_v = 32'sd0;
    end else begin
      shift_v = shift_v;
    end
    case (shift_v)
      32'sd0:  mask = 3'b000;
      32'sd1:  mask = 3'b001;
      32'sd2:  mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return (frm & mask) == 3'b000;
  endfunction

  logic clk, rst_n;
  assign clk   = SC_LANESCHEDULER_CLOCK_50;
  assign rst_n = SC_LANESCHEDULER_RESET_InLow;

  state_t                     state_r, state_s;
  logic [PRESCALER_WIDTH-1:0] presc_r, presc_s;
  logic [2:0]                 frame_r, frame_s;
  logic [IDX_W-1:0]           idx_r, idx_s;
  logic                       req_r, req_s;
  logic [NUM_LANES-1:0]       left_r, left_s;
  logic [NUM_LANES-1:0]       right_r, right_s;
  logic                       chk_r, chk_s;
  logic                       busy_r, busy_s;
  logic [NUM_LANES-1:0]       lane_onehot_s;

  assign lane_onehot_s = NUM_LANES'(1) << idx_r;

  // Next-state and next-output decode; outputs are computed for the state
  // being entered so they line up with it once registered.
  always_comb begin
    state_s = state_r;
    presc_s = presc_r;
    frame_s = frame_r;
    idx_s   = idx_r;
    req_s   = 1'b1;
    left_s  = {NUM_LANES{1'b0}};
    right_s = {NUM_LANES{1'b0}};
    chk_s   = 1'b1;
    busy_s  = 1'b1;
    if ((state_r != ST_IDLE) && !SC_LANESCHEDULER_startGame_InLow) begin
      // Restart wins over everything, including an outstanding request.
      state_s = ST_WAIT_TICK;
      presc_s = {PRESCALER_WIDTH{1'b0}};
      frame_s = 3'd0;
      idx_s   = {IDX_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!SC_LANESCHEDULER_startGame_InLow) begin
            state_s = ST_WAIT_TICK;
            presc_s = {PRESCALER_WIDTH{1'b0}};
            frame_s = 3'd0;
            idx_s   = {IDX_W{1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT_TICK: begin
          if (SC_LANESCHEDULER_pause_InLow) begin
            if (presc_r == TERM_COUNT) begin
              presc_s = {PRESCALER_WIDTH{1'b0}};
              frame_s = frame_r + 3'd1;
              idx_s   = {IDX_W{1'b0}};
              state_s = ST_SCAN;
              busy_s  = 1'b0;
            end else begin
              presc_s = presc_r + PRESCALER_WIDTH'(1);
            end
          end else begin
            presc_s = presc_r;
          end
        end
        ST_SCAN: begin
          busy_s = 1'b0;
          if (lane_eligible(idx_r, SC_LANESCHEDULER_level_InBUS, frame_r)) begin
            // Direction is captured here and held for the whole request.
            state_s = ST_REQ;
            req_s   = 1'b0;
            if (SC_LANESCHEDULER_laneDir_InBUS[idx_r]) begin
              right_s = lane_onehot_s;
            end else begin
              left_s = lane_onehot_s;
            end
          end else if (idx_r == LAST_IDX) begin
            state_s = ST_COLLIDE;
            chk_s   = 1'b0;
            idx_s   = {IDX_W{1'b0}};
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end
        ST_REQ: begin
          busy_s = 1'b0;
          if (!SC_LANESCHEDULER_shiftAck_InLow) begin
            if (idx_r == LAST_IDX) begin
              state_s = ST_COLLIDE;
              chk_s   = 1'b0;
              idx_s   = {IDX_W{1'b0}};
            end else begin
              state_s = ST_SCAN;
              idx_s   = idx_r + IDX_W'(1);
            end
          end else begin
            req_s   = 1'b0;
            left_s  = left_r;
            right_s = right_r;
          end
        end
        ST_COLLIDE: begin
          state_s = ST_WAIT_TICK;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      presc_r <= {PRESCALER_WIDTH{1'b0}};
      frame_r <= 3'd0;
      idx_r   <= {IDX_W{1'b0}};
      req_r   <= 1'b1;
      left_r  <= {NUM_LANES{1'b0}};
      right_r <= {NUM_LANES{1'b0}};
      chk_r   <= 1'b1;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      presc_r <= presc_s;
      frame_r <= frame_s;
      idx_r   <= idx_s;
      req_r   <= req_s;
      left_r  <= left_s;
      right_r <= right_s;
      chk_r   <= chk_s;
      busy_r  <= busy_s;
    end
  end

  assign SC_LANESCHEDULER_shiftReq_OutLow       = req_r;
  assign SC_LANESCHEDULER_shiftLeft_OutBUS      = left_r;
  assign SC_LANESCHEDULER_shiftRight_OutBUS     = right_r;
  assign SC_LANESCHEDULER_checkCollision_OutLow = chk_r;
  assign SC_LANESCHEDULER_busy_OutLow           = busy_r;

endmodule

// File: tb/tb_sc_lanescheduler.sv
// Self-checking bench for sc_lanescheduler: expected request sequences per
// sweep are computed from the frame/level rules and queued; a monitor pops
// and compares whenever the scheduler presents a request or collision strobe.
module tb_sc_lanescheduler;

  localparam int TB_BP = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_n;
  logic       pause_n;
  logic [1:0] level;
  logic [7:0] lane_dir;
  logic       ack_n;
  logic       req_n;
  logic [7:0] left_bus;
  logic [7:0] right_bus;
  logic       chk_n;
  logic       busy_n;

  typedef struct {
    bit collide;
    int lane;
    bit right;
  } exp_t;

  exp_t exp_q[$];
  int   tests       = 0;
  int   fails       = 0;
  int   sweeps_done = 0;
  int   ack_fixed   = 0;
  bit   check_len   = 1'b0;
  int   model_frame = 0;

  sc_lanescheduler #(
    .NUM_LANES(8), .PRESCALER_WIDTH(22), .BASE_PERIOD(TB_BP), .LEVEL_WIDTH(2)
  ) dut (
    .SC_LANESCHEDULER_CLOCK_50             (clk),
    .SC_LANESCHEDULER_RESET_InLow          (rst_n),
    .SC_LANESCHEDULER_startGame_InLow      (start_n),
    .SC_LANESCHEDULER_pause_InLow          (pause_n),
    .SC_LANESCHEDULER_level_InBUS          (level),
    .SC_LANESCHEDULER_laneDir_InBUS        (lane_dir),
    .SC_LANESCHEDULER_shiftAck_InLow       (ack_n),
    .SC_LANESCHEDULER_shiftReq_OutLow      (req_n),
    .SC_LANESCHEDULER_shiftLeft_OutBUS     (left_bus),
    .SC_LANESCHEDULER_shiftRight_OutBUS    (right_bus),
    .SC_LANESCHEDULER_checkCollision_OutLow(chk_n),
    .SC_LANESCHEDULER_busy_OutLow          (busy_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference model: a lane moves in frame f when f is a multiple of
  // 2^max(lane%4 - level, 0). Each sweep ends with one collision strobe.
  task automatic push_sweep();
    exp_t e;
    int   s;
    model_frame = (model_frame + 1) % 8;
    for (int lane = 0; lane < 8; lane++) begin
      s = (lane % 4) - int'(level);
      if (s < 0) s = 0;
      if ((model_frame % (1 << s)) == 0) begin
        e.collide = 1'b0;
        e.lane    = lane;
        e.right   = lane_dir[lane];
        exp_q.push_back(e);
      end
    end
    e.collide = 1'b1;
    e.lane    = 0;
    e.right   = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_sweep(input int limit, input bit rand_pause);
    int start_cnt;
    int n;
    start_cnt = sweeps_done;
    n = 0;
    while (sweeps_done == start_cnt && n < limit) begin
      @(negedge clk);
      n++;
      if (rand_pause) pause_n = ($urandom_range(0, 3) != 0);
    end
    pause_n = 1'b1;
    tests++;
    if (sweeps_done == start_cnt) begin
      fails++;
      $display("FAIL sweep_timeout: got no collision strobe within %0d cycles, expected one", limit);
    end
  endtask

  task automatic wait_req_low(input int limit);
    int n;
    n = 0;
    while (req_n && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", 32'(req_n), 32'd0);
  endtask

  // Lane-bank responder: acknowledges each request after a programmable delay.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    ack_n = 1'b1;
    forever begin
      @(negedge clk);
      if (!req_n && rst_n) begin
        if (wait_cnt <= 0) begin
          ack_n = 1'b0;
        end else begin
          ack_n = 1'b1;
          wait_cnt--;
        end
      end else begin
        ack_n = 1'b1;
        wait_cnt = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
      end
    end
  end

  // Monitor: pops the scoreboard on every new request and every strobe.
  initial begin
    bit          req_prev;
    int          low_len;
    logic [15:0] cap;
    logic [15:0] want;
    logic [7:0]  one8;
    logic [7:0]  onehot;
    exp_t        e;
    req_prev = 1'b1;
    low_len  = 0;
    cap      = 16'h0000;
    forever begin
      @(negedge clk);
      if (!req_n) begin
        if (req_prev) begin
          low_len = 1;
          cap = {left_bus, right_bus};
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL req_unexpected: got request %h, expected none", {left_bus, right_bus});
          end else begin
            e = exp_q.pop_front();
            check("req_kind", 32'(e.collide), 32'd0);
            one8 = 8'd1;
            onehot = one8 << e.lane;
            want = e.right ? {8'h00, onehot} : {onehot, 8'h00};
            check("req_lane", 32'({left_bus, right_bus}), 32'(want));
          end
        end else begin
          low_len++;
          check("req_hold", 32'({left_bus, right_bus}), 32'(cap));
        end
        check("busy_during_req", 32'(busy_n), 32'd0);
      end else begin
        if (!req_prev && check_len) check("ack_len", 32'(low_len), 32'(ack_fixed + 1));
        check("idle_buses", 32'({left_bus, right_bus}), 32'd0);
      end
      if (!chk_n) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL collide_unexpected: got strobe, expected none");
        end else begin
          e = exp_q.pop_front();
          check("collide_kind", 32'(e.collide), 32'd1);
        end
        check("busy_collide", 32'(busy_n), 32'd0);
        sweeps_done++;
      end
      req_prev = req_n;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n    = 1'b1;
    start_n  = 1'b1;
    pause_n  = 1'b1;
    level    = 2'd0;
    lane_dir = 8'h10;
    #1 rst_n = 1'b0;
    #2;
    check("reset_outputs", 32'({req_n, chk_n, busy_n, left_bus, right_bus}),
          32'({1'b1, 1'b1, 1'b1, 16'h0000}));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'({req_n, chk_n, busy_n, left_bus, right_bus}),
            32'({1'b1, 1'b1, 1'b1, 16'h0000}));
    end

    // First game: 20-cycle pause mid-prescale, ack answered at once.
    ack_fixed = 0;
    check_len = 1'b1;
    push_sweep();
    @(negedge clk) start_n = 1'b0;
    @(negedge clk) start_n = 1'b1;
    @(negedge clk) pause_n = 1'b0;
    for (int i = 2; i <= 21; i++) begin
      @(negedge clk);
      check("pause_no_tick", 32'(busy_n), 32'd1);
    end
    pause_n = 1'b1;
    cnt = 21;
    while (busy_n && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("tick_latency", 32'(cnt), 32'(TB_BP + 20));
    @(negedge clk);
    check("first_req_latency", 32'(req_n), 32'd0);
    wait_sweep(1000, 1'b0);

    // Frames 2..7 and the wrap to 0 at level 0, then level 3.
    for (int f = 2; f <= 8; f++) begin
      push_sweep();
      wait_sweep(1000, 1'b0);
    end
    level = 2'd3;
    lane_dir = 8'hA5;
    push_sweep();
    wait_sweep(1000, 1'b0);

    // Ack held high for 5 cycles on every request.
    ack_fixed = 5;
    push_sweep();
    wait_sweep(1000, 1'b0);

    // Randomized levels, directions, ack delays and pauses.
    ack_fixed = -1;
    check_len = 1'b0;
    for (int k = 0; k < 25; k++) begin
      level = 2'($urandom_range(0, 3));
      lane_dir = 8'($urandom);
      push_sweep();
      wait_sweep(1000, 1'b1);
    end

    // Abort during a request; the next sweep must restart at frame 1.
    ack_fixed = 0;
    level = 2'd0;
    if ((model_frame % 2) == 1) begin
      push_sweep();
      wait_sweep(1000, 1'b0);
    end
    ack_fixed = 50;
    lane_dir = 8'($urandom);
    push_sweep();
    wait_req_low(1000);
    repeat (2) @(negedge clk);
    check("abort_pre_req", 32'(req_n), 32'd0);
    start_n = 1'b0;
    @(negedge clk);
    check("abort_req", 32'(req_n), 32'd1);
    check("abort_buses", 32'({left_bus, right_bus}), 32'd0);
    check("abort_busy", 32'(busy_n), 32'd1);
    start_n = 1'b1;
    exp_q.delete();
    model_frame = 0;
    ack_fixed = 0;
    lane_dir = 8'h10;
    push_sweep();
    wait_sweep(1000, 1'b0);

    // Asynchronous reset in the middle of a request.
    ack_fixed = 3;
    level = 2'd3;
    push_sweep();
    wait_req_low(1000);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 32'({req_n, chk_n, busy_n, left_bus, right_bus}),
          32'({1'b1, 1'b1, 1'b1, 16'h0000}));
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_reset_idle", 32'({req_n, chk_n, busy_n}), 32'({1'b1, 1'b1, 1'b1}));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
